// File: rtl/fb_line_writer_if.sv
// Request handshake and framebuffer write port shared by the line writer and its client.
// The slave modport is the line writer's view; master is the renderer/arbiter side.
interface fb_line_writer_if #(
    parameter int CORDW  = 10,
    parameter int COLORW = 3
);
    logic              start;
    logic [CORDW-1:0]  x0;
    logic [CORDW-1:0]  y0;
    logic [CORDW-1:0]  x1;
    logic [CORDW-1:0]  y1;
    logic [COLORW-1:0] color_in;
    logic              stall;
    logic              busy;
    logic              done;
    logic              we;
    logic [CORDW-1:0]  x;
    logic [CORDW-1:0]  y;
    logic [COLORW-1:0] color;

    modport master (
        output start, x0, y0, x1, y1, color_in, stall,
        input  busy, done, we, x, y, color
    );

    modport slave (
        input  start, x0, y0, x1, y1, color_in, stall,
        output busy, done, we, x, y, color
    );
endinterface

// File: rtl/fb_line_writer.sv
// Bresenham line walker feeding the framebuffer write port, one pixel per non-stalled cycle.
// The current walk point lives directly in the x/y output registers.
module fb_line_writer #(
    parameter int CORDW  = 10,
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int COLORW = 3
) (
    input  logic            clk,
    input  logic            rst,
    fb_line_writer_if.slave bus
);
    localparam int SW = CORDW + 2;
    localparam logic [CORDW:0]   WIDTH_C  = (CORDW + 1)'(WIDTH);
    localparam logic [CORDW:0]   HEIGHT_C = (CORDW + 1)'(HEIGHT);
    localparam logic [CORDW-1:0] ONE_C    = {{(CORDW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 we_r, we_s;
    logic [CORDW-1:0]     x_r, x_s, y_r, y_s;
    logic [CORDW-1:0]     x1_r, x1_s, y1_r, y1_s;
    logic [COLORW-1:0]    color_r, color_s;
    logic                 sx_r, sx_s, sy_r, sy_s;
    logic signed [SW-1:0] dx_r, dx_s, dy_r, dy_s, err_r, err_s;
    logic signed [SW-1:0] xd_s, yd_s, e2_s, err_a_s;

    function automatic logic in_frame(input logic [CORDW-1:0] px, input logic [CORDW-1:0] py);
        return ({1'b0, px} < WIDTH_C) && ({1'b0, py} < HEIGHT_C);
    endfunction

    function automatic logic [CORDW-1:0] step(input logic [CORDW-1:0] p, input logic up);
        if (up) begin
            return p + ONE_C;
        end else begin
            return p - ONE_C;
        end
    endfunction

    // Next-state and next-output logic for the walk FSM
    always_comb begin
        state_s = state_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        we_s    = we_r;
        x_s     = x_r;
        y_s     = y_r;
        x1_s    = x1_r;
        y1_s    = y1_r;
        color_s = color_r;
        sx_s    = sx_r;
        sy_s    = sy_r;
        dx_s    = dx_r;
        dy_s    = dy_r;
        err_s   = err_r;
        err_a_s = err_r;
        xd_s    = $signed({2'b00, x1_r}) - $signed({2'b00, x_r});
        yd_s    = $signed({2'b00, y1_r}) - $signed({2'b00, y_r});
        e2_s    = $signed({err_r[SW-2:0], 1'b0});

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_INIT;
                    busy_s  = 1'b1;
                    x_s     = bus.x0;
                    y_s     = bus.y0;
                    x1_s    = bus.x1;
                    y1_s    = bus.y1;
                    color_s = bus.color_in;
                end else begin
                    busy_s  = 1'b0;
                    we_s    = 1'b0;
                end
            end
            ST_INIT: begin
                // dx is kept positive, dy negative, as the error term expects
                sx_s    = ~xd_s[SW-1];
                sy_s    = ~yd_s[SW-1];
                dx_s    = xd_s[SW-1] ? -xd_s : xd_s;
                dy_s    = yd_s[SW-1] ? yd_s : -yd_s;
                err_s   = dx_s + dy_s;
                we_s    = in_frame(x_r, y_r);
                state_s = ST_DRAW;
            end
            ST_DRAW: begin
                if (bus.stall) begin
                    state_s = ST_DRAW;
                end else if ((x_r == x1_r) && (y_r == y1_r)) begin
                    state_s = ST_DONE;
                    we_s    = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    // Both axis tests use the error doubled before either update
                    if (e2_s >= dy_r) begin
                        err_a_s = err_a_s + dy_r;
                        x_s     = step(x_r, sx_r);
                    end else begin
                        x_s     = x_r;
                    end
                    if (e2_s <= dx_r) begin
                        err_a_s = err_a_s + dx_r;
                        y_s     = step(y_r, sy_r);
                    end else begin
                        y_s     = y_r;
                    end
                    err_s = err_a_s;
                    we_s  = in_frame(x_s, y_s);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                we_s    = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                we_s    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            we_r    <= 1'b0;
            x_r     <= {CORDW{1'b0}};
            y_r     <= {CORDW{1'b0}};
            x1_r    <= {CORDW{1'b0}};
            y1_r    <= {CORDW{1'b0}};
            color_r <= {COLORW{1'b0}};
            sx_r    <= 1'b0;
            sy_r    <= 1'b0;
            dx_r    <= {SW{1'b0}};
            dy_r    <= {SW{1'b0}};
            err_r   <= {SW{1'b0}};
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            we_r    <= we_s;
            x_r     <= x_s;
            y_r     <= y_s;
            x1_r    <= x1_s;
            y1_r    <= y1_s;
            color_r <= color_s;
            sx_r    <= sx_s;
            sy_r    <= sy_s;
            dx_r    <= dx_s;
            dy_r    <= dy_s;
            err_r   <= err_s;
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.we    = we_r;
    assign bus.x     = x_r;
    assign bus.y     = y_r;
    assign bus.color = color_r;
endmodule

// File: tb/tb_fb_line_writer.sv
// Self-checking bench for fb_line_writer: directed lines from the test plan plus
// random lines with random stalls compared against an integer Bresenham model.
module tb_fb_line_writer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_line_writer_if #(.CORDW(10), .COLORW(3)) bus ();
    fb_line_writer #(.CORDW(10), .WIDTH(10), .HEIGHT(10), .COLORW(3)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic       we;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] col;
        logic       busy;
        logic       done;
        logic       stall;
    } obs_t;

    obs_t tr[$];
    int   mx[$];
    int   my[$];
    logic init_busy, init_we;
    int   chk  = 0;
    int   errs = 0;

    // Expected pixel sequence of a segment, straight from the integer Bresenham rules
    function automatic void build_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int ddx, ddy, ssx, ssy, e, e2, cx, cy;
        mx.delete(); my.delete();
        ddx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
        ddy = -((ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1);
        ssx = (ax1 >= ax0) ? 1 : -1;
        ssy = (ay1 >= ay0) ? 1 : -1;
        e = ddx + ddy; cx = ax0; cy = ay0;
        for (int n = 0; n < 4096; n++) begin
            mx.push_back(cx); my.push_back(cy);
            if (cx == ax1 && cy == ay1) break;
            e2 = 2 * e;
            if (e2 >= ddy) begin e += ddy; cx += ssx; end
            if (e2 <= ddx) begin e += ddx; cy += ssy; end
        end
    endfunction

    // Issue one segment and record every cycle from the first pixel slot through done
    task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1,
                        input int col, input int smode, input bit restart);
        obs_t o;
        int held;
        tr.delete(); held = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.x0 = 10'(ax0); bus.y0 = 10'(ay0);
        bus.x1 = 10'(ax1); bus.y1 = 10'(ay1); bus.color_in = 3'(col);
        @(negedge clk);
        bus.start = restart;
        bus.x0 = 10'($urandom_range(0, 15)); bus.y0 = 10'($urandom_range(0, 15));
        bus.x1 = 10'($urandom_range(0, 15)); bus.y1 = 10'($urandom_range(0, 15));
        bus.color_in = 3'($urandom);
        init_busy = bus.busy; init_we = bus.we;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            o.we = bus.we; o.x = bus.x; o.y = bus.y; o.col = bus.color;
            o.busy = bus.busy; o.done = bus.done;
            case (smode)
                1: bus.stall = ($urandom_range(0, 2) == 0);
                2: begin
                    bus.stall = (bus.x == 10'd1 && bus.y == 10'd1 && held < 3);
                    if (bus.stall) held++;
                end
                default: bus.stall = 1'b0;
            endcase
            o.stall = bus.stall;
            tr.push_back(o);
            if (o.done) break;
        end
        bus.start = 1'b0; bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.stall = 1'b0; bus.x0 = 10'd0; bus.y0 = 10'd0;
        bus.x1 = 10'd0; bus.y1 = 10'd0; bus.color_in = 3'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.we !== 1'b0 || bus.x !== 10'd0 ||
            bus.y !== 10'd0 || bus.color !== 3'd0) begin
            errs++;
            $display("FAIL reset_values: busy=%b done=%b we=%b x=%0d y=%0d color=%0d, required all 0",
                     bus.busy, bus.done, bus.we, bus.x, bus.y, bus.color);
        end
        rst = 1'b0;
        @(negedge clk);
        chk++;
        if (bus.busy !== 1'b0 || bus.we !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle: busy=%b we=%b, required 0 0", bus.busy, bus.we);
        end
    endtask

    task automatic test_horizontal();
        draw(0, 0, 4, 0, 5, 0, 1'b0);
        chk++;
        if (init_busy !== 1'b1 || init_we !== 1'b0) begin
            errs++; $display("FAIL horiz_init: busy=%b we=%b, required 1 0", init_busy, init_we);
        end
        chk++;
        if (tr.size() != 6) begin
            errs++; $display("FAIL horiz_len: %0d cycles to done, required 6", tr.size());
        end
        for (int i = 0; i < 5 && i < tr.size(); i++) begin
            chk++;
            if (tr[i].we !== 1'b1 || tr[i].x !== 10'(i) || tr[i].y !== 10'd0 ||
                tr[i].col !== 3'b101 || tr[i].busy !== 1'b1 || tr[i].done !== 1'b0) begin
                errs++;
                $display("FAIL horiz_px%0d: we=%b (%0d,%0d) col=%b busy=%b, required we=1 (%0d,0) col=101 busy=1",
                         i, tr[i].we, tr[i].x, tr[i].y, tr[i].col, tr[i].busy, i);
            end
        end
        if (tr.size() == 6) begin
            chk++;
            if (tr[5].done !== 1'b1 || tr[5].busy !== 1'b0 || tr[5].we !== 1'b0) begin
                errs++;
                $display("FAIL horiz_done: done=%b busy=%b we=%b, required 1 0 0",
                         tr[5].done, tr[5].busy, tr[5].we);
            end
        end
    endtask

    task automatic test_steep_reverse();
        int ex[7] = '{6, 5, 5, 4, 3, 3, 2};
        int ey[7] = '{6, 5, 4, 3, 2, 1, 0};
        draw(6, 6, 2, 0, 3, 0, 1'b0);
        chk++;
        if (tr.size() != 8) begin
            errs++; $display("FAIL steep_len: %0d cycles to done, required 8", tr.size());
        end
        for (int i = 0; i < 7 && i < tr.size(); i++) begin
            chk++;
            if (tr[i].we !== 1'b1 || tr[i].x !== 10'(ex[i]) || tr[i].y !== 10'(ey[i]) ||
                tr[i].col !== 3'b011 || tr[i].busy !== 1'b1) begin
                errs++;
                $display("FAIL steep_px%0d: we=%b (%0d,%0d) col=%b busy=%b, required we=1 (%0d,%0d) col=011 busy=1",
                         i, tr[i].we, tr[i].x, tr[i].y, tr[i].col, tr[i].busy, ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_clip();
        draw(8, 0, 12, 0, 7, 0, 1'b0);
        chk++;
        if (tr.size() != 6 || tr[tr.size()-1].done !== 1'b1) begin
            errs++; $display("FAIL clip_len: %0d cycles to done, required 6", tr.size());
        end
        for (int i = 0; i < 5 && i < tr.size(); i++) begin
            chk++;
            if (tr[i].we !== ((8 + i) < 10) || tr[i].x !== 10'(8 + i) || tr[i].y !== 10'd0) begin
                errs++;
                $display("FAIL clip_px%0d: we=%b (%0d,%0d), required we=%b (%0d,0)",
                         i, tr[i].we, tr[i].x, tr[i].y, ((8 + i) < 10), 8 + i);
            end
        end
    endtask

    task automatic test_stall();
        int ex[7] = '{0, 1, 1, 1, 1, 2, 3};
        draw(0, 0, 3, 3, 1, 2, 1'b0);
        chk++;
        if (tr.size() != 8) begin
            errs++; $display("FAIL stall_len: %0d cycles to done, required 8", tr.size());
        end
        for (int i = 0; i < 7 && i < tr.size(); i++) begin
            chk++;
            if (tr[i].we !== 1'b1 || tr[i].x !== 10'(ex[i]) || tr[i].y !== 10'(ex[i])) begin
                errs++;
                $display("FAIL stall_px%0d: we=%b (%0d,%0d), required we=1 (%0d,%0d)",
                         i, tr[i].we, tr[i].x, tr[i].y, ex[i], ex[i]);
            end
        end
    endtask

    task automatic test_handshake();
        draw(3, 3, 3, 3, 2, 0, 1'b1);
        chk++;
        if (tr.size() != 2 || tr[0].we !== 1'b1 || tr[0].x !== 10'd3 || tr[0].y !== 10'd3 ||
            tr[tr.size()-1].done !== 1'b1) begin
            errs++;
            $display("FAIL single_point: %0d cycles, first we=%b (%0d,%0d), required 2 cycles we=1 (3,3)",
                     tr.size(), tr[0].we, tr[0].x, tr[0].y);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk++;
            if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errs++;
                $display("FAIL ignored_start%0d: we=%b busy=%b done=%b, required 0 0 0",
                         i, bus.we, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ew;
        int k;
        @(negedge clk);
        bus.start = 1'b1; bus.x0 = 10'd0; bus.y0 = 10'd0; bus.x1 = 10'd9; bus.y1 = 10'd0;
        bus.color_in = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk++;
        if (bus.we !== 1'b1 || bus.x !== 10'd2) begin
            errs++; $display("FAIL mid_third_px: we=%b x=%0d, required 1 2", bus.we, bus.x);
        end
        rst = 1'b1;
        @(negedge clk);
        chk++;
        if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.x !== 10'd0 ||
            bus.y !== 10'd0 || bus.color !== 3'd0) begin
            errs++;
            $display("FAIL mid_abort: we=%b busy=%b done=%b x=%0d y=%0d color=%0d, required all 0",
                     bus.we, bus.busy, bus.done, bus.x, bus.y, bus.color);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk++;
            if (bus.done !== 1'b0 || bus.we !== 1'b0 || bus.busy !== 1'b0) begin
                errs++;
                $display("FAIL mid_no_done%0d: done=%b we=%b busy=%b, required 0 0 0",
                         i, bus.done, bus.we, bus.busy);
            end
        end
        draw(2, 1, 7, 3, 6, 0, 1'b0);
        build_model(2, 1, 7, 3);
        chk++;
        if (tr.size() != mx.size() + 1) begin
            errs++; $display("FAIL after_reset_len: %0d cycles, required %0d", tr.size(), mx.size() + 1);
        end
        k = 0;
        for (int i = 0; i < tr.size() - 1 && k < mx.size(); i++) begin
            ew = (mx[k] < 10) && (my[k] < 10);
            chk++;
            if (tr[i].we !== ew || tr[i].x !== 10'(mx[k]) || tr[i].y !== 10'(my[k]) || tr[i].col !== 3'd6) begin
                errs++;
                $display("FAIL after_reset_px%0d: we=%b (%0d,%0d) col=%0d, required we=%b (%0d,%0d) col=6",
                         i, tr[i].we, tr[i].x, tr[i].y, tr[i].col, ew, mx[k], my[k]);
            end
            k++;
        end
    endtask

    task automatic test_random_lines();
        int ax0, ay0, ax1, ay1, col, k, npix;
        logic ew;
        for (int t = 0; t < 12; t++) begin
            ax0 = $urandom_range(0, 13); ay0 = $urandom_range(0, 13);
            ax1 = $urandom_range(0, 13); ay1 = $urandom_range(0, 13);
            col = $urandom_range(0, 7);
            build_model(ax0, ay0, ax1, ay1);
            npix = (((ax1 > ax0) ? ax1 - ax0 : ax0 - ax1) > ((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1)) ?
                   ((ax1 > ax0) ? ax1 - ax0 : ax0 - ax1) + 1 : ((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1) + 1;
            draw(ax0, ay0, ax1, ay1, col, 1, 1'b0);
            chk++;
            if (tr.size() == 0 || tr[tr.size()-1].done !== 1'b1) begin
                errs++;
                $display("FAIL rand%0d_timeout: no done within %0d cycles", t, tr.size());
                continue;
            end
            k = 0;
            for (int i = 0; i < tr.size() - 1; i++) begin
                chk++;
                if (k >= mx.size()) begin
                    errs++;
                    $display("FAIL rand%0d_extra: pixel (%0d,%0d) beyond %0d expected pixels",
                             t, tr[i].x, tr[i].y, mx.size());
                end else begin
                    ew = (mx[k] < 10) && (my[k] < 10);
                    if (tr[i].we !== ew || tr[i].x !== 10'(mx[k]) || tr[i].y !== 10'(my[k]) ||
                        tr[i].col !== 3'(col) || tr[i].busy !== 1'b1) begin
                        errs++;
                        $display("FAIL rand%0d_px%0d: we=%b (%0d,%0d) col=%0d busy=%b, required we=%b (%0d,%0d) col=%0d busy=1",
                                 t, i, tr[i].we, tr[i].x, tr[i].y, tr[i].col, tr[i].busy, ew, mx[k], my[k], col);
                    end
                end
                if (!tr[i].stall) k++;
            end
            chk++;
            if (k != npix) begin
                errs++; $display("FAIL rand%0d_count: %0d pixel steps, required %0d", t, k, npix);
            end
            chk++;
            if (tr[tr.size()-1].busy !== 1'b0 || tr[tr.size()-1].we !== 1'b0) begin
                errs++;
                $display("FAIL rand%0d_done: busy=%b we=%b in done cycle, required 0 0",
                         t, tr[tr.size()-1].busy, tr[tr.size()-1].we);
            end
            @(negedge clk);
            chk++;
            if (bus.done !== 1'b0) begin
                errs++; $display("FAIL rand%0d_pulse: done=%b one cycle after done, required 0", t, bus.done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep_reverse();
        test_clip();
        test_stall();
        test_handshake();
        test_reset_mid();
        test_random_lines();
        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end
endmodule

// File: doc/fb_line_writer.md
# fb_line_writer

Line-drawing write engine for the vga_cube framebuffer. Accepts a segment (x0,y0)→(x1,y1) plus a color via a start/busy/done handshake and walks it with integer Bresenham, one pixel per cycle. Drives the framebuffer write port (we, x, y, color) directly. It is the producer of the writes the framebuffer consumes, and it is what the cube renderer calls once per edge.

## Interface
Parameters:
- CORDW, 10, coordinate width; matches framebuffer CORDW
- WIDTH, 10, framebuffer width in pixels; clip limit for x
- HEIGHT, 10, framebuffer height in pixels; clip limit for y
- COLORW, 3, color width; matches framebuffer COLORW

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- x0, y0  in  CORDW  start point, unsigned
- x1, y1  in  CORDW  end point, unsigned
- color_in  in  COLORW  line color
- stall  in  1  write port not available this cycle (arbiter shares port with clear/scanout)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel
- we  out  1  framebuffer write enable
- x, y  out  CORDW  framebuffer write coordinate
- color  out  COLORW  framebuffer write color

## Operation
- States: IDLE → INIT → DRAW → DONE → IDLE.
- IDLE: ignore all inputs except start.
  - start=1: latch x0,y0,x1,y1,color_in and go to INIT.
- INIT: compute the walk parameters, then go to DRAW with the current point = (x0,y0).
  - dx = |x1−x0|, dy = −|y1−y0|
  - sx/sy = +1 if end ≥ start, else −1
  - err = dx+dy
  - All walk arithmetic is signed, CORDW+2 bits wide; e2 = 2·err.
- DRAW, each non-stalled cycle:
  - Present the current point on x/y with color.
  - we=1 only if x<WIDTH and y<HEIGHT. An out-of-range pixel (clip) still consumes one step, with we=0.
  - If current point = (x1,y1), go to DONE.
  - Otherwise: if e2 ≥ dy then err+=dy, x+=sx; if e2 ≤ dx then err+=dx, y+=sy. Both updates apply in the same step and use the pre-update e2.
- Stall: when stall=1 in DRAW, x/y/color/we and all walk state are held. A held we=1 rewrites the same pixel, which is harmless.
- DONE: we=0, done=1, busy=0 for one cycle, then IDLE.
- start while busy is ignored; no queuing.
- Pixel count = max(dx,|dy|)+1.
- Reset values:
  - State IDLE.
  - busy=0, done=0, we=0, x=0, y=0, color=0.
- Reset mid-draw: abort immediately. we=0 from the next cycle, no done pulse.
- Inputs x0..y1 and color_in may change after the start cycle without effect.

## Timing
- All outputs are registered.
- start is sampled at edge N; busy=1 and INIT occupy cycle N+1.
- The first pixel (we/x/y valid) is presented in cycle N+2.
- Pixel k is presented in cycle N+2+k plus the number of stalled cycles before it.
- done is high in the cycle after the last pixel. busy falls in that same cycle.
- Earliest next start is sampled in the done cycle+1 (IDLE).
- Single-pixel line (x0=x1, y0=y1): one write in N+2, done in N+3.
- stall is sampled every cycle. It only affects the DRAW state.

## Test plan
- Horizontal line (0,0)→(4,0), color 3'b101:
  - we=1 for 5 consecutive cycles starting 2 cycles after start, x=0..4, y=0, color=101.
  - done one cycle later.
- Steep reverse line (6,6)→(2,0), color 3'b011:
  - Exactly 7 writes in order (6,6),(5,5),(5,4),(4,3),(3,2),(3,1),(2,0).
  - Then done; busy high throughout.
- Clipping, (8,0)→(12,0) with WIDTH=10:
  - 5 steps: we=1 at x=8,9 and we=0 at x=10,11,12.
  - done after the 5th step.
- Stall, (0,0)→(3,3):
  - stall high for 3 cycles while (1,1) is presented: (1,1) is held for 4 cycles.
  - Total draw is 7 cycles instead of 4; pixel order is unchanged.
- Handshake, single point (3,3)→(3,3):
  - One write, then done.
  - A second start asserted during busy is ignored: no extra writes.
- Reset mid-draw of (0,0)→(9,0):
  - Assert rst during the 3rd pixel: next cycle we=0, busy=0, x=y=0, state IDLE.
  - No done pulse.
  - A new start after reset draws correctly.
